step_pulse_generator: RTL
=========================

// Module: step_pulse_generator
// PURPOSE
//   Front end that drives an up/down step accumulator from two raw push buttons.
//   Per button: 2-flop synchronizer, then debouncer.
//   Then emits clean, mutually exclusive single-cycle inc/dec strobes, with auto-repeat while a button is held.
//   All logic runs on one clock, so downstream counters run on clk and use the strobes as enables.
// PARAMETERS
//   DEBOUNCE_CYC   16   consecutive stable synced cycles before debounced level changes (>=1)
//   REPEAT_DELAY   500  cycles from first pulse to first auto-repeat pulse (>=2)
//   REPEAT_RATE    100  cycles between subsequent auto-repeat pulses (>=2)
// PORTS
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous, active-low reset
//   btn_plus   in   1  raw "up" button, asynchronous, bouncy, active-high
//   btn_minus  in   1  raw "down" button, asynchronous, bouncy, active-high
//   inc_pulse  out  1  one-cycle increment strobe
//   dec_pulse  out  1  one-cycle decrement strobe
//   key_held   out  1  high while a single accepted press is in DELAY or REPEAT
// BEHAVIOUR
//   Reset (reset=0): async clear of all flops.
//   - Synchronizers, debounced levels and debounce counters = 0.
//   - Timer = 0, FSM = IDLE, inc_pulse = dec_pulse = key_held = 0.
//   - After reset is released, a button that is still held is detected again as a new press.
//   Synchronizer: 2 flops per button. The synced value lags the raw input by 2 clk edges.
//   Debounce, per button:
//   - The counter increments while synced != debounced, and clears on any cycle where they match.
//   - When the counter reaches DEBOUNCE_CYC, debounced <= synced and the counter clears.
//   FSM (on debounced levels db_p, db_m):
//   - IDLE
//     - db_p & !db_m: inc_pulse=1 next cycle; dir=UP; timer=REPEAT_DELAY; -> DELAY.
//     - db_m & !db_p: same with dec_pulse and dir=DN.
//     - db_p & db_m: -> LOCKOUT, no pulse.
//   - DELAY
//     - Active button released: -> IDLE.
//     - Opposite button debounced high: -> LOCKOUT.
//     - Otherwise the timer decrements. At 1 -> 0: pulse in dir, timer=REPEAT_RATE, -> REPEAT.
//   - REPEAT
//     - Release and conflict rules are the same as DELAY.
//     - At timer expiry: pulse in dir, reload REPEAT_RATE.
//   - LOCKOUT: no pulses. -> IDLE only when db_p=0 and db_m=0.
//   Release and conflict checks take priority over timer expiry in the same cycle.
//   Outputs are registered.
//   - Pulse latency from the first clk edge that samples a stable raw high is 2+DEBOUNCE_CYC+1 edges.
//   - inc_pulse and dec_pulse are never high together and never high on two consecutive cycles.
//   - Pulse spacing: first -> second = REPEAT_DELAY cycles; then REPEAT_RATE cycles each.
//   - key_held = 1 exactly while the FSM is in DELAY or REPEAT.
//   - A release that is debounced in the same cycle a pulse is issued does not cancel that pulse.
//   Timer width = $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1). Debounce counter width = $clog2(DEBOUNCE_CYC+1).
// TESTING (bench params DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_RATE=5)
//   1. Clean press: btn_plus 0->1 sampled at edge 0, held 15 cycles.
//      -> exactly one inc_pulse, at edge 7; dec_pulse stays 0; key_held rises at edge 7.
//   2. Bounce: btn_plus toggles every 2 cycles for 12 cycles, then is stable high for 10 cycles.
//      -> exactly one inc_pulse, 7 edges after the last toggle.
//   3. Hold btn_minus 50 cycles from edge 0.
//      -> dec_pulse at edges 7, 27, 32, 37, 42, 47, 52.
//      -> no pulse after the debounced release; key_held falls when the FSM enters IDLE.
//   4. btn_plus and btn_minus rise on the same edge, held 20 cycles, both released, then btn_plus pressed.
//      -> no pulses during the dual hold; one inc_pulse 7 edges after the new press.
//   5. Hold btn_plus into REPEAT, then press btn_minus.
//      -> inc pulses stop once db_m=1; no dec_pulse; key_held=0; IDLE only after both are released.
//   6. reset=0 for 3 cycles mid-REPEAT while btn_plus stays held.
//      -> all outputs 0 immediately and asynchronously; new inc_pulse 7 edges after reset deasserts.

Source files
------------

// File: rtl/step_pulse_generator.sv
// rtl/step_pulse_generator.sv - debounced up/down step strobes with auto-repeat
//
// Purpose: turns two raw, bouncy push buttons into clean, mutually exclusive
// single-cycle inc/dec strobes. Each button passes through a 2-flop
// synchronizer and a stability-count debouncer. A small FSM then issues one
// strobe per accepted press, followed by auto-repeat strobes while the button
// stays held. Pressing both buttons locks the outputs out until both are
// released.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-low reset
//   btn_plus   in   raw "up" button (async, bouncy, active-high)
//   btn_minus  in   raw "down" button (async, bouncy, active-high)
//   inc_pulse  out  one-cycle increment strobe (registered)
//   dec_pulse  out  one-cycle decrement strobe (registered)
//   key_held   out  high while an accepted single press is in DELAY or REPEAT

module step_pulse_generator #(
   parameter int DEBOUNCE_CYC = 16,
   parameter int REPEAT_DELAY = 500,
   parameter int REPEAT_RATE  = 100
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_plus,
   input  logic btn_minus,
   output logic inc_pulse,
   output logic dec_pulse,
   output logic key_held
);

   localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int CW   = $clog2(DEBOUNCE_CYC + 1);

   localparam logic [TW-1:0] DELAY_LD = TW'(REPEAT_DELAY);
   localparam logic [TW-1:0] RATE_LD  = TW'(REPEAT_RATE);
   localparam logic [TW-1:0] TIMER_ONE = TW'(1);
   localparam logic [CW-1:0] DB_MAX   = CW'(DEBOUNCE_CYC);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DELAY   = 2'd1,
      ST_REPEAT  = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_t;

   // Index 0 = plus button, index 1 = minus button.
   logic [1:0]    sync1_q, sync1_d;
   logic [1:0]    sync2_q, sync2_d;
   logic [1:0]    db_q, db_d;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          dir_q, dir_d;        // 0 = up (plus), 1 = down (minus)
   logic          inc_pulse_q, inc_pulse_d;
   logic          dec_pulse_q, dec_pulse_d;
   logic          key_held_q, key_held_d;

   logic          db_p, db_m;
   logic          act_btn, opp_btn;

   // Synchronizer and debouncer. The counter must sit at DEBOUNCE_CYC for one
   // more mismatching cycle before the debounced level is updated, which gives
   // the 2 + DEBOUNCE_CYC + 1 edge press-to-pulse latency.
   always_comb begin
      sync1_d = {btn_minus, btn_plus};
      sync2_d = sync1_q;
      db_d    = db_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != db_q[i]) begin
            if (cnt_q[i] == DB_MAX) begin
               db_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign db_p = db_q[0];
   assign db_m = db_q[1];

   // Press FSM. Release and conflict checks are evaluated before timer expiry
   // so a pending repeat never fires once the press is no longer valid.
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      dir_d       = dir_q;
      inc_pulse_d = 1'b0;
      dec_pulse_d = 1'b0;
      act_btn     = dir_q ? db_m : db_p;
      opp_btn     = dir_q ? db_p : db_m;

      case (state_q)
         ST_IDLE: begin
            if (db_p && db_m) begin
               state_d = ST_LOCKOUT;
            end else if (db_p) begin
               inc_pulse_d = 1'b1;
               dir_d       = 1'b0;
               timer_d     = DELAY_LD;
               state_d     = ST_DELAY;
            end else if (db_m) begin
               dec_pulse_d = 1'b1;
               dir_d       = 1'b1;
               timer_d     = DELAY_LD;
               state_d     = ST_DELAY;
            end
         end

         ST_DELAY, ST_REPEAT: begin
            if (!act_btn) begin
               state_d = ST_IDLE;
            end else if (opp_btn) begin
               state_d = ST_LOCKOUT;
            end else if (timer_q == TIMER_ONE) begin
               inc_pulse_d = ~dir_q;
               dec_pulse_d = dir_q;
               timer_d     = RATE_LD;
               state_d     = ST_REPEAT;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end

         ST_LOCKOUT: begin
            if (!db_p && !db_m) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      key_held_d = (state_d == ST_DELAY) || (state_d == ST_REPEAT);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q     <= '0;
         sync2_q     <= '0;
         db_q        <= '0;
         cnt_q[0]    <= '0;
         cnt_q[1]    <= '0;
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         dir_q       <= 1'b0;
         inc_pulse_q <= 1'b0;
         dec_pulse_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         db_q        <= db_d;
         cnt_q[0]    <= cnt_d[0];
         cnt_q[1]    <= cnt_d[1];
         state_q     <= state_d;
         timer_q     <= timer_d;
         dir_q       <= dir_d;
         inc_pulse_q <= inc_pulse_d;
         dec_pulse_q <= dec_pulse_d;
         key_held_q  <= key_held_d;
      end
   end

   assign inc_pulse = inc_pulse_q;
   assign dec_pulse = dec_pulse_q;
   assign key_held  = key_held_q;

endmodule
